// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by decode, the register file and the ALU.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Register index field positions in an R-type instruction word.
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;

  function automatic logic [ADDR_W-1:0] reg_field(input logic [DATA_W-1:0] instr,
                                                  input int unsigned lsb);
    return instr[lsb +: ADDR_W];
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two registered read ports with write-through bypass,
// one write port, and the ALU zero flag registered for branch resolution.
module reg_file
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              hold,
  input  logic              wr_file,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] result,
  input  logic              zero,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic              zero_q
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] input1_q, input1_d;
  logic [DATA_W-1:0] input2_q, input2_d;
  logic              zero_qq, zero_d;
  logic              wr_en;

  assign wr_en = wr_file && (rd_addr != REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rd_addr] = result;
    end
    regs_d[REG_ZERO] = '0;
  end

  // Same-cycle write is forwarded so decode never has to stall on a RAW hazard.
  always_comb begin
    input1_d = regs_q[rs_addr];
    if (wr_file && (rd_addr == rs_addr)) begin
      input1_d = result;
    end
    if (rs_addr == REG_ZERO) begin
      input1_d = '0;
    end

    input2_d = regs_q[rt_addr];
    if (wr_file && (rd_addr == rt_addr)) begin
      input2_d = result;
    end
    if (rt_addr == REG_ZERO) begin
      input2_d = '0;
    end

    zero_d = zero & wr_file;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      input1_q <= '0;
      input2_q <= '0;
      zero_qq  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      if (!hold) begin
        input1_q <= input1_d;
        input2_q <= input2_d;
        zero_qq  <= zero_d;
      end
    end
  end

  assign input1 = input1_q;
  assign input2 = input2_q;
  assign zero_q = zero_qq;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: array-based reference model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        hold, wr_file, zero;
  logic [31:0] result;
  logic [31:0] input1, input2;
  logic        zero_q;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] exp1, exp2;
  logic        expz;

  always #5 clk = ~clk;

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .hold    (hold),
    .wr_file (wr_file),
    .rd_addr (rd_addr),
    .result  (result),
    .zero    (zero),
    .input1  (input1),
    .input2  (input2),
    .zero_q  (zero_q)
  );

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_file && rd_addr == a) return result;
    return m_regs[a];
  endfunction

  // Reference model: evaluate the read rules first, then commit the write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      exp1 = 32'h0;
      exp2 = 32'h0;
      expz = 1'b0;
    end else begin
      if (!hold) begin
        exp1 = m_read(rs_addr);
        exp2 = m_read(rt_addr);
        expz = zero & wr_file;
      end
      if (wr_file && rd_addr != 5'd0) m_regs[rd_addr] = result;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_input1", input1, exp1);
      check("model_input2", input2, exp2);
      check("model_zero_q", {31'h0, zero_q}, {31'h0, expz});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic h, input logic w, input logic [4:0] rd,
                     input logic [31:0] res, input logic [4:0] rs, input logic [4:0] rt,
                     input logic z);
    rst = r; hold = h; wr_file = w; rd_addr = rd; result = res;
    rs_addr = rs; rt_addr = rt; zero = z;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] e1, input logic [31:0] e2,
                     input logic ez);
    check({name, "_in1"}, input1, e1);
    check({name, "_in2"}, input2, e2);
    check({name, "_zq"}, {31'h0, zero_q}, {31'h0, ez});
    check({name, "_model1"}, exp1, e1);
  endtask

  initial begin
    set(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cmp_en = 1'b1;

    // Reset clears a preloaded register.
    set(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0); cycle();
    set(1, 0, 0, 0, 0, 5, 0, 0);            cycle();
    lit("reset", 32'h0, 32'h0, 1'b0);
    set(0, 0, 0, 0, 0, 5, 5, 0);            cycle();
    lit("reset_rd5", 32'h0, 32'h0, 1'b0);

    // Write then read one cycle later.
    set(0, 0, 1, 8, 32'h64, 0, 0, 0);       cycle();
    set(0, 0, 0, 0, 0, 8, 8, 0);            cycle();
    lit("wr_rd", 32'h64, 32'h64, 1'b0);

    // Same-cycle bypass on port 1, storage on port 2.
    set(0, 0, 1, 10, 32'h5, 0, 0, 0);       cycle();
    set(0, 0, 1, 9, 32'h12345678, 9, 10, 0); cycle();
    lit("bypass", 32'h12345678, 32'h5, 1'b0);
    set(0, 0, 0, 0, 0, 9, 9, 0);            cycle();
    lit("bypass_commit", 32'h12345678, 32'h12345678, 1'b0);

    // Register 0 ignores writes and bypass.
    set(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0); cycle();
    lit("r0_same", 32'h0, 32'h0, 1'b0);
    set(0, 0, 0, 0, 0, 0, 0, 0);            cycle();
    lit("r0_later", 32'h0, 32'h0, 1'b0);

    // Hold freezes outputs while a write commits.
    set(0, 0, 0, 0, 0, 8, 10, 0);           cycle();
    lit("pre_hold", 32'h64, 32'h5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set(0, 1, 1, 3, 32'hA5A5A5A5, 3, 3, 1); cycle();
      lit("hold", 32'h64, 32'h5, 1'b0);
    end
    set(0, 0, 0, 0, 0, 3, 0, 0);            cycle();
    lit("post_hold", 32'hA5A5A5A5, 32'h0, 1'b0);

    // Zero flag capture requires an ALU write.
    set(0, 0, 1, 7, 32'h1, 7, 0, 1);        cycle();
    lit("zero_wr", 32'h1, 32'h0, 1'b1);
    set(0, 0, 0, 0, 0, 7, 0, 1);            cycle();
    lit("zero_nowr", 32'h1, 32'h0, 1'b0);

    // Reset beats write and hold.
    set(1, 1, 1, 4, 32'h77, 4, 4, 1);       cycle();
    lit("rst_prio", 32'h0, 32'h0, 1'b0);
    set(0, 0, 0, 0, 0, 4, 3, 0);            cycle();
    lit("rst_cleared", 32'h0, 32'h0, 1'b0);

    // Mixed vectors over a few registers so bypass and hold collide often.
    for (int i = 0; i < 60; i++) begin
      set(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
          5'($urandom_range(0, 5)), $urandom, 5'($urandom_range(0, 5)),
          5'($urandom_range(0, 5)), 1'($urandom));
      cycle();
    end

    set(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

32 x 32-bit MIPS general-purpose register file with two registered read ports and one write-back port. It sits between decode and the ALU. Its read ports supply the ALU operands (input1, input2). Its write port consumes the ALU's result/wr_file write-back pair. It also latches the ALU zero flag for the branch logic on the following cycle.

## Interface
- DATA_W, 32, register and operand width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rs_addr  in  ADDR_W  read port 1 index (rs field)
- rt_addr  in  ADDR_W  read port 2 index (rt field)
- hold  in  1  stall: freeze read outputs and zero_q
- wr_file  in  1  write enable from ALU
- rd_addr  in  ADDR_W  write index
- result  in  DATA_W  write data from ALU
- zero  in  1  ALU zero flag
- input1  out  DATA_W  registered read data, port 1 (to ALU input1)
- input2  out  DATA_W  registered read data, port 2 (to ALU input2)
- zero_q  out  1  ALU zero flag registered for branch resolution

## Operation
- Storage: regs[0..31]. Register 0 is hardwired to 0.
  - Writes with rd_addr=0 are discarded.
  - Reads of index 0 return 0 regardless of bypass.
- Write: at a rising edge with rst=0, wr_file=1 and rd_addr!=0, regs[rd_addr] <= result. Writes are never blocked by hold.
- Read: at a rising edge with rst=0 and hold=0, input1 <= value(rs_addr) and input2 <= value(rt_addr).
- value(a):
  - 0 if a=0;
  - else result if wr_file=1 and rd_addr=a in that same cycle (write-through bypass);
  - else regs[a].
- Bypass applies independently to both ports. rs_addr=rt_addr=rd_addr gives the bypassed value on both outputs.
- zero_q: at a rising edge with rst=0 and hold=0, zero_q <= zero & wr_file. It is 0 when no ALU write is in progress.
- hold=1: input1, input2 and zero_q keep their previous values.
  - A write during hold still commits.
  - The held output is not refreshed. The first read after hold deasserts returns the new contents.
- No other state; no FSM beyond register storage and output registers.

## Timing
- Reset: on a rising edge with rst=1:
  - all regs[*] = 0, input1 = 0, input2 = 0, zero_q = 0;
  - any write presented that cycle is dropped;
  - rst has priority over hold and wr_file.
- Read latency: address sampled at edge N, data valid after edge N (one cycle).
- Write latency: data committed at edge N. A non-bypassed read sampled at edge N+1 or later sees it.
- Write-then-read spacing of 0 cycles is covered by the bypass. No stall is ever required by this block.
- Reset deasserted mid-sequence: the first edge with rst=0 behaves as a normal cycle on cleared contents.

## Structure
- Shared package mips_pkg: DATA_W, ADDR_W, REG_ZERO (index 0) and the rs/rt/rd field bit positions. The ALU and decode use the same constants.
- No sub-module. Storage, bypass muxes and output registers live in one module. The bypass compare is written once per port.
- Storage is flop-based (sync reset of all entries is required), not inferred RAM.

## Test plan
- Reset: preload regs[5]=0xDEADBEEF, assert rst one cycle, read rs=5 -> input1=0, input2=0, zero_q=0 after the next edge.
- Write then read: write regs[8]=0x00000064 at edge N. Read rs=8, rt=8 at edge N+1 -> input1=input2=0x00000064 after edge N+1.
- Bypass: at the same edge, write rd=9 result=0x12345678 and read rs=9, rt=10 (regs[10]=0x5) -> input1=0x12345678, input2=0x5. regs[9]=0x12345678 thereafter.
- Register 0: write rd=0 result=0xFFFFFFFF with rs=0 in the same cycle -> input1=0 on that cycle and on every later read of 0.
- Hold: hold=1 for 3 cycles while writing regs[3]=0xA5A5A5A5 with rs=3. Outputs stay at the pre-hold value, and zero_q stays unchanged when zero=1. Release hold -> input1=0xA5A5A5A5 on the next edge.
- Zero capture and reset priority:
  - wr_file=1, zero=1 -> zero_q=1.
  - wr_file=0, zero=1 -> zero_q=0.
  - rst=1 with wr_file=1, rd=4 -> regs[4] reads 0 afterwards.
